// File: rtl/button_pkg.sv
// Shared timing defaults and counter sizing helper for the push-button front end.
package button_pkg;

  localparam int DEBOUNCE_10MS_50MHZ       = 500000;
  localparam int REPEAT_DELAY_500MS_50MHZ  = 25000000;
  localparam int REPEAT_PERIOD_100MS_50MHZ = 5000000;

  // Bits needed to hold values 0..max_val inclusive; never less than 1.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, stability-counter debounce, edge pulses and auto-repeat.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS_50MHZ,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bt_in_i,
  input  logic repeat_en_i,
  output logic bt_level_o,
  output logic bt_press_o,
  output logic bt_release_o,
  output logic bt_repeat_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(REPEAT_DELAY + REPEAT_PERIOD);
  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [RW-1:0]          rcnt_q, rcnt_d, rcnt_inc;
  logic                   level_q, level_d;
  logic                   press_q, release_q, repeat_q, repeat_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    dcnt_d  = '0;
    level_d = level_q;
    if (s != level_q) begin
      if (dcnt_q == D_LAST) level_d = s;
      else                  dcnt_d  = dcnt_q + 1'b1;
    end
  end

  // rcnt runs only while held on both sides of the edge, so the press and
  // release edges clear it. After the first repeat it cycles
  // DELAY..DELAY+PERIOD-1, which keeps it bounded for holds of any length.
  always_comb begin
    rcnt_inc = rcnt_q + 1'b1;
    rcnt_d   = '0;
    repeat_d = 1'b0;
    if (level_q && level_d && repeat_en_i) begin
      rcnt_d   = (rcnt_inc == R_WRAP) ? R_FIRST : rcnt_inc;
      repeat_d = (rcnt_d == R_FIRST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bt_in_i};
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      level_q   <= level_d;
      press_q   <= level_d & ~level_q;
      release_q <= level_q & ~level_d;
      repeat_q  <= repeat_d;
    end
  end

  assign bt_level_o   = level_q;
  assign bt_press_o   = press_q;
  assign bt_release_o = release_q;
  assign bt_repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: N_BTN independent button_channel instances.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS_50MHZ,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS_50MHZ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] bt_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] bt_level,
  output logic [N_BTN-1:0] bt_press,
  output logic [N_BTN-1:0] bt_release,
  output logic [N_BTN-1:0] bt_repeat
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .bt_in_i     (bt_in[g]),
      .repeat_en_i (repeat_en[g]),
      .bt_level_o  (bt_level[g]),
      .bt_press_o  (bt_press[g]),
      .bt_release_o(bt_release[g]),
      .bt_repeat_o (bt_repeat[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bounce against a behavioural model.
module tb_button_conditioner;

  localparam int NB    = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int DELAY = 10;
  localparam int PER   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] bt_in, repeat_en;
  logic [NB-1:0] bt_level, bt_press, bt_release, bt_repeat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  button_conditioner #(
    .N_BTN(NB), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bt_in(bt_in), .repeat_en(repeat_en),
    .bt_level(bt_level), .bt_press(bt_press), .bt_release(bt_release),
    .bt_repeat(bt_repeat)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Level flips once the synchronised input has disagreed for DEB edges in a
  // row; repeats fall on hold lengths DELAY, DELAY+PER, ... counted without bound.
  int m_sync[NB][SYNC];
  int m_level[NB], m_mis[NB], m_held[NB];
  logic [NB-1:0] e_level = '0, e_press = '0, e_release = '0, e_repeat = '0;
  int ms, mnl;

  initial begin
    for (int c = 0; c < NB; c++) begin
      m_level[c] = 0; m_mis[c] = 0; m_held[c] = 0;
      for (int k = 0; k < SYNC; k++) m_sync[c][k] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NB; c++) begin
        m_level[c] = 0; m_mis[c] = 0; m_held[c] = 0;
        for (int k = 0; k < SYNC; k++) m_sync[c][k] = 0;
      end
      e_level = '0; e_press = '0; e_release = '0; e_repeat = '0;
    end else begin
      for (int c = 0; c < NB; c++) begin
        ms = m_sync[c][SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
        m_sync[c][0] = bt_in[c] ? 1 : 0;
        mnl = m_level[c];
        if (ms != m_level[c]) begin
          m_mis[c]++;
          if (m_mis[c] == DEB) begin
            mnl = ms;
            m_mis[c] = 0;
          end
        end else begin
          m_mis[c] = 0;
        end
        e_press[c]   = (m_level[c] == 0) && (mnl == 1);
        e_release[c] = (m_level[c] == 1) && (mnl == 0);
        if (m_level[c] == 1 && mnl == 1 && repeat_en[c]) m_held[c]++;
        else m_held[c] = 0;
        e_repeat[c] = (m_held[c] >= DELAY) && (((m_held[c] - DELAY) % PER) == 0);
        m_level[c]  = mnl;
        e_level[c]  = (mnl != 0);
      end
    end
  end

  // ---------------- compare + event log (opposite edge) ----------------
  int press_cnt[NB]   = '{0, 0, 0, 0};
  int release_cnt[NB] = '{0, 0, 0, 0};
  int rep_cnt[NB]     = '{0, 0, 0, 0};
  int last_press[NB]  = '{0, 0, 0, 0};
  int last_rel[NB]    = '{0, 0, 0, 0};
  int rep_q2[$];
  int rep_q3[$];

  always @(negedge clk) begin
    chk("level",   int'(bt_level),   int'(e_level));
    chk("press",   int'(bt_press),   int'(e_press));
    chk("release", int'(bt_release), int'(e_release));
    chk("repeat",  int'(bt_repeat),  int'(e_repeat));
    for (int c = 0; c < NB; c++) begin
      if (bt_press[c])   begin press_cnt[c]++;   last_press[c] = cyc; end
      if (bt_release[c]) begin release_cnt[c]++; last_rel[c]   = cyc; end
      if (bt_repeat[c]) begin
        rep_cnt[c]++;
        if (c == 2) rep_q2.push_back(cyc);
        if (c == 3) rep_q3.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int e, p, f, r, snap;
  int dur[NB];

  initial begin
    rst_n = 1'b0; bt_in = '0; repeat_en = '0;
    idle(3);
    chk("rst_level",   int'(bt_level),   0);
    chk("rst_press",   int'(bt_press),   0);
    chk("rst_release", int'(bt_release), 0);
    chk("rst_repeat",  int'(bt_repeat),  0);
    rst_n = 1'b1;
    idle(2);

    // clean press / release on channel 0
    e = cyc; bt_in[0] = 1'b1;
    wait_cyc(e + 20); f = cyc; bt_in[0] = 1'b0;
    wait_cyc(f + 10);
    chk("s1_press_time", last_press[0], e + 6);
    chk("s1_press_cnt",  press_cnt[0], 1);
    chk("s1_rel_time",   last_rel[0], f + 6);
    chk("s1_rel_cnt",    release_cnt[0], 1);
    chk("s1_others",     press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

    // bounce then settle on channel 1, then a 3-cycle glitch
    e = cyc; bt_in[1] = 1'b1; idle(1);
    bt_in[1] = 1'b0; idle(1);
    bt_in[1] = 1'b1; idle(1);
    bt_in[1] = 1'b0; idle(1);
    f = cyc; bt_in[1] = 1'b1;
    wait_cyc(f + 12);
    chk("s2_press_time", last_press[1], f + 6);
    chk("s2_press_cnt",  press_cnt[1], 1);
    bt_in[1] = 1'b0; idle(3); bt_in[1] = 1'b1; idle(10);
    chk("s2_glitch_rel", release_cnt[1], 0);
    chk("s2_glitch_lvl", int'(bt_level[1]), 1);
    chk("s2_no_repeat",  rep_cnt[1], 0);
    bt_in[1] = 1'b0; idle(10);

    // auto-repeat on channel 2
    repeat_en[2] = 1'b1;
    e = cyc; p = e + 6; bt_in[2] = 1'b1;
    wait_cyc(p + 30); bt_in[2] = 1'b0;
    wait_cyc(p + 50);
    chk("s3_rep_cnt", rep_q2.size(), 9);
    chk("s3_rep0", rep_q2.size() > 0 ? rep_q2[0] : -1, p + 10);
    chk("s3_rep1", rep_q2.size() > 1 ? rep_q2[1] : -1, p + 13);
    chk("s3_rep2", rep_q2.size() > 2 ? rep_q2[2] : -1, p + 16);
    chk("s3_rep3", rep_q2.size() > 3 ? rep_q2[3] : -1, p + 19);
    chk("s3_rep8", rep_q2.size() > 8 ? rep_q2[8] : -1, p + 34);
    chk("s3_rel_time", last_rel[2], p + 36);
    repeat_en[2] = 1'b0;

    // repeat enable toggling on channel 3; release lands on a repeat slot
    repeat_en[3] = 1'b1;
    e = cyc; p = e + 6; bt_in[3] = 1'b1;
    wait_cyc(p + 5);  repeat_en[3] = 1'b0;
    wait_cyc(p + 12); repeat_en[3] = 1'b1;
    wait_cyc(p + 25); bt_in[3] = 1'b0;
    wait_cyc(p + 40);
    chk("s4_rep_cnt", rep_q3.size(), 3);
    chk("s4_rep0", rep_q3.size() > 0 ? rep_q3[0] : -1, p + 22);
    chk("s4_rep2", rep_q3.size() > 2 ? rep_q3[2] : -1, p + 28);
    chk("s4_rel_time", last_rel[3], p + 31);
    repeat_en[3] = 1'b0;
    snap = rep_cnt[3];
    bt_in[3] = 1'b1; idle(30); bt_in[3] = 1'b0; idle(10);
    chk("s4_no_rep_disabled", rep_cnt[3], snap);

    // reset during a hold (ch1) and mid-debounce (ch0)
    e = cyc; bt_in[1] = 1'b1;
    wait_cyc(e + 8); bt_in[0] = 1'b1;
    wait_cyc(e + 12);
    chk("s5_held_before", int'(bt_level[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_level", int'(bt_level), 0);
    chk("s5_rst_pulses", int'(bt_press | bt_release | bt_repeat), 0);
    idle(3);
    r = cyc; rst_n = 1'b1;
    wait_cyc(r + 10);
    chk("s5_press0", last_press[0], r + 6);
    chk("s5_press1", last_press[1], r + 6);
    bt_in = '0; idle(10);

    // simultaneous press on all channels, independent release on ch0
    e = cyc; bt_in = 4'hF;
    wait_cyc(e + 10); bt_in[0] = 1'b0; snap = release_cnt[1] + release_cnt[2] + release_cnt[3];
    wait_cyc(e + 20);
    for (int c = 0; c < NB; c++) chk("s6_press_time", last_press[c], e + 6);
    chk("s6_rel0", last_rel[0], e + 16);
    chk("s6_levels", int'(bt_level), 4'b1110);
    chk("s6_others_held", release_cnt[1] + release_cnt[2] + release_cnt[3], snap);
    bt_in = '0; idle(10);

    // random bounce, long holds, repeat toggling and occasional reset
    for (int c = 0; c < NB; c++) dur[c] = 1;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NB; c++) begin
        dur[c]--;
        if (dur[c] <= 0) begin
          bt_in[c] = ~bt_in[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
        end
      end
      if ($urandom_range(0, 15) == 0) repeat_en[$urandom_range(0, NB - 1)] ^= 1'b1;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
      idle(1);
    end

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel push-button front end: synchronises each raw button input to `clk`, debounces it with a per-channel stability counter, and emits single-cycle press, release and optional auto-repeat pulses. Sits between board button pins and control FSMs / menu logic. Each button press yields exactly one press pulse, regardless of contact bounce or how long the button is held.

## Interface
- `N_BTN`, 4: number of independent button channels.
- `SYNC_STAGES`, 2: synchroniser flop depth; must be ≥2.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a new level must persist before acceptance (10 ms at 50 MHz); must be ≥1.
- `REPEAT_DELAY`, 25000000: cycles from press pulse to first repeat pulse; must be ≥1.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent repeat pulses; must be ≥1.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bt_in` in N_BTN: raw asynchronous button levels, active high.
- `repeat_en` in N_BTN: per-channel auto-repeat enable, synchronous to `clk`.
- `bt_level` out N_BTN: debounced, registered button level.
- `bt_press` out N_BTN: one-cycle pulse on accepted 0→1.
- `bt_release` out N_BTN: one-cycle pulse on accepted 1→0.
- `bt_repeat` out N_BTN: one-cycle auto-repeat pulse while held.

## Operation
- Channels are fully independent; the description below is per channel.
- Synchroniser: `bt_in` passes through `SYNC_STAGES` flops; the last stage is `s`.
- Debounce: counter `dcnt`; if `s == bt_level`, `dcnt` ← 0. Otherwise, if `dcnt == DEBOUNCE_CYCLES-1`, `bt_level` ← `s` and `dcnt` ← 0; otherwise `dcnt` ← `dcnt`+1.
- Any mismatch shorter than `DEBOUNCE_CYCLES` cycles is discarded and `dcnt` restarts from 0.
- `bt_press` / `bt_release` are registered and assert in the same cycle `bt_level` changes. They are never both high. Each is high for exactly one cycle.
- Repeat counter `rcnt` is held at 0 while `bt_level == 0` or `repeat_en == 0`.
- Otherwise `rcnt` counts. `bt_repeat` pulses when `rcnt` reaches `REPEAT_DELAY` (first repeat), then every `REPEAT_PERIOD` cycles after that, until release.
- The press cycle itself never produces `bt_repeat`.
- `repeat_en` falling while held: `rcnt` clears immediately and no further repeat pulses occur.
- `repeat_en` rising while held: counting starts from 0, so the first repeat comes `REPEAT_DELAY` cycles later.
- Release clears `rcnt` in the same cycle `bt_release` pulses. If a repeat would coincide with release, the release wins and no repeat pulse is issued.
- Counter widths: `$clog2` of (max parameter value + 1). Counters must not wrap during a hold of any length.

## Timing
- Reset values (async, active-low): all sync flops, `dcnt`, `rcnt`, `bt_level`, `bt_press`, `bt_release`, `bt_repeat` = 0.
- Button held across reset release: produces a normal press pulse once debounce completes.
- Press latency: edge 1 is the first rising edge that samples the new `bt_in` level. With `bt_in` stable from then on, `bt_press` and `bt_level` are visible after edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- Release latency: identical to press latency.
- First `bt_repeat` comes exactly `REPEAT_DELAY` cycles after the `bt_press` cycle. Later repeats are spaced `REPEAT_PERIOD` cycles apart.
- Reset asserted mid-debounce or mid-hold: everything clears at once, with no pulse generated during or on exit from reset.
- `rst_n` deassertion is assumed synchronised externally to `clk`.

## Structure
- Sub-module `button_channel`: holds the synchroniser, debounce counter and repeat counter for one bit. The top instantiates `N_BTN` copies in a generate loop.
- Shared package `button_pkg` holds:
  - default timing constants (`DEBOUNCE_10MS_50MHZ`, `REPEAT_DELAY_500MS_50MHZ`, `REPEAT_PERIOD_100MS_50MHZ`);
  - a width function `cnt_width(max)`.
- No typedefs are needed.

## Test plan
Bench parameters for all scenarios: `N_BTN`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.

- **Clean press/release:** `bt_in[0]` 0→1 held 20 cycles, then 1→0 → `bt_press[0]` a single pulse after edge 6; `bt_level[0]`=1 from then; `bt_release[0]` a single pulse 6 edges after the fall; other channels stay 0.
- **Bounce:** `bt_in[1]` toggles 1,0,1,0 for 1 cycle each, then 1 held → exactly one `bt_press[1]`, 6 edges after the final rise; a 3-cycle glitch alone → no pulse, `bt_level` unchanged.
- **Auto-repeat:** `repeat_en[2]`=1, `bt_in[2]` held 30 cycles after press → `bt_repeat[2]` at press+10, +13, +16, +19, …; none after the `bt_release[2]` cycle.
- **Repeat enable toggling:** hold `bt_in[3]`; drop `repeat_en[3]` at press+5, raise it at press+12 → first repeat at press+22; no repeat on a press with `repeat_en`=0.
- **Reset mid-operation:** assert `rst_n`=0 during debounce (`dcnt`=2) and during a hold → all outputs 0 immediately; after reset release with the button still high, `bt_press` arrives 6 edges later.
- **Simultaneous channels:** all 4 `bt_in` rise on the same edge → all 4 `bt_press` bits pulse in the same cycle; an independent release on channel 0 does not disturb the others.
